// File: rtl/filter_iir1_tdm.sv
// ---------------------------------------------------------------------------
// filter_iir1_tdm
//
// First-order IIR filter, H(z) = (b0 + b1*z^-1) / (1 + a1*z^-1), shared in
// time over CHANNELS independent channel states.  Direct form II:
//   w[n] = x[n] - a1*w[n-1]
//   y[n] = b0*w[n] + b1*w[n-1]
// Coefficients and bypass are sampled together with each input sample, so
// any change takes effect exactly on a sample boundary.  All products are
// formed at full width, rounded half-up, and every narrowing saturates.
//
// Pipeline (one sample per clock, in_valid -> out_valid is 4 edges):
//   S1  register sample, channel, coefficients, bypass
//   S2  read state[ch], compute w, write state[ch], register w / w_prev
//   S3  register the two rounded b-products
//   S4  sum, saturate, scale, drive outputs
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     input sample strobe
//   in_channel   channel of the input sample (>= CHANNELS: sample dropped)
//   in           signed input sample
//   b0, b1, a1   signed coefficients (a1 is the denominator sign as written)
//   bypass       pass the sample through unfiltered (state still updated)
//   clear        zero every channel state at the next edge
//   out_valid    one-cycle result strobe
//   out_channel  channel of the result (held between strobes)
//   out          signed result (held between strobes)
// ---------------------------------------------------------------------------
module filter_iir1_tdm #(
  parameter int DATA_WIDTH = 9,
  parameter int CHANNELS   = 2,
  parameter int COEF_WIDTH = 12,
  parameter int A_FRAC     = 10,
  parameter int B_FRAC     = 10,
  parameter int GUARD      = 1,
  localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [CW-1:0]                in_channel,
  input  logic signed [DATA_WIDTH-1:0] in,
  input  logic signed [COEF_WIDTH-1:0] b0,
  input  logic signed [COEF_WIDTH-1:0] b1,
  input  logic signed [COEF_WIDTH-1:0] a1,
  input  logic                         bypass,
  input  logic                         clear,
  output logic                         out_valid,
  output logic [CW-1:0]                out_channel,
  output logic signed [DATA_WIDTH-1:0] out
);

  localparam int IW = DATA_WIDTH + GUARD + 1;  // internal state width
  localparam int PW = IW + COEF_WIDTH;         // full product width
  localparam int AW = PW + 2;                  // accumulate width, never wraps

  localparam logic [CW:0]              CH_LIM = (CW+1)'(CHANNELS);
  localparam logic signed [AW-1:0]     RND_A  = AW'(1 << (A_FRAC - 1));
  localparam logic signed [AW-1:0]     RND_B  = AW'(1 << (B_FRAC - 1));
  localparam logic signed [AW-1:0]     IW_MAX = AW'((1 << (IW - 1)) - 1);
  localparam logic signed [AW-1:0]     IW_MIN = ~IW_MAX;
  localparam logic signed [IW-1:0]     DW_MAX = IW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [IW-1:0]     DW_MIN = ~DW_MAX;

  function automatic logic signed [IW-1:0] sat_iw(input logic signed [AW-1:0] v);
    if (v > IW_MAX)      return IW_MAX[IW-1:0];
    else if (v < IW_MIN) return IW_MIN[IW-1:0];
    else                 return v[IW-1:0];
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat_dw(input logic signed [IW-1:0] v);
    if (v > DW_MAX)      return DW_MAX[DATA_WIDTH-1:0];
    else if (v < DW_MIN) return DW_MIN[DATA_WIDTH-1:0];
    else                 return v[DATA_WIDTH-1:0];
  endfunction

  // ---------------- S1: capture ----------------
  logic                         s1_valid;
  logic [CW-1:0]                s1_ch;
  logic signed [DATA_WIDTH-1:0] s1_x;
  logic signed [COEF_WIDTH-1:0] s1_b0, s1_b1, s1_a1;
  logic                         s1_bypass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_ch     <= '0;
      s1_x      <= '0;
      s1_b0     <= '0;
      s1_b1     <= '0;
      s1_a1     <= '0;
      s1_bypass <= 1'b0;
    end else begin
      // Out-of-range channels never become valid, so they touch no state.
      s1_valid  <= in_valid && ({1'b0, in_channel} < CH_LIM);
      s1_ch     <= in_channel;
      s1_x      <= in;
      s1_b0     <= b0;
      s1_b1     <= b1;
      s1_a1     <= a1;
      s1_bypass <= bypass;
    end
  end

  // ---------------- S2: recursion ----------------
  logic signed [IW-1:0] state [CHANNELS];
  logic signed [IW-1:0] w_prev;
  logic signed [IW-1:0] x_iw;
  logic signed [PW-1:0] prod_a;
  logic signed [AW-1:0] acc_a;
  logic signed [AW-1:0] diff;
  logic signed [IW-1:0] w_new;

  always_comb begin
    // Channel mux written as a compare loop so an unused index never reads
    // past the end of the state array.
    w_prev = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (s1_ch == CW'(i)) w_prev = state[i];
    end
    // A sample meeting clear sees an already-cleared history.
    if (clear) w_prev = '0;

    x_iw   = IW'(s1_x) <<< GUARD;
    prod_a = PW'(s1_a1) * PW'(w_prev);
    acc_a  = (AW'(prod_a) + RND_A) >>> A_FRAC;
    // Denominator sign is applied here: w = x - a1*w_prev.
    diff   = AW'(x_iw) - acc_a;
    w_new  = sat_iw(diff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) state[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < CHANNELS; i++) state[i] <= '0;
    end else if (s1_valid) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (s1_ch == CW'(i)) state[i] <= w_new;
      end
    end
  end

  logic                         s2_valid;
  logic [CW-1:0]                s2_ch;
  logic signed [IW-1:0]         s2_w, s2_wp;
  logic signed [COEF_WIDTH-1:0] s2_b0, s2_b1;
  logic                         s2_bypass;
  logic signed [DATA_WIDTH-1:0] s2_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_ch     <= '0;
      s2_w      <= '0;
      s2_wp     <= '0;
      s2_b0     <= '0;
      s2_b1     <= '0;
      s2_bypass <= 1'b0;
      s2_raw    <= '0;
    end else begin
      s2_valid  <= s1_valid;
      s2_ch     <= s1_ch;
      s2_w      <= w_new;
      s2_wp     <= w_prev;
      s2_b0     <= s1_b0;
      s2_b1     <= s1_b1;
      s2_bypass <= s1_bypass;
      s2_raw    <= s1_x;
    end
  end

  // ---------------- S3: numerator products ----------------
  logic signed [PW-1:0] prod_b0, prod_b1;
  logic signed [AW-1:0] rnd_b0, rnd_b1;

  always_comb begin
    prod_b0 = PW'(s2_b0) * PW'(s2_w);
    prod_b1 = PW'(s2_b1) * PW'(s2_wp);
    rnd_b0  = (AW'(prod_b0) + RND_B) >>> B_FRAC;
    rnd_b1  = (AW'(prod_b1) + RND_B) >>> B_FRAC;
  end

  logic                         s3_valid;
  logic [CW-1:0]                s3_ch;
  logic signed [AW-1:0]         s3_p0, s3_p1;
  logic                         s3_bypass;
  logic signed [DATA_WIDTH-1:0] s3_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid  <= 1'b0;
      s3_ch     <= '0;
      s3_p0     <= '0;
      s3_p1     <= '0;
      s3_bypass <= 1'b0;
      s3_raw    <= '0;
    end else begin
      s3_valid  <= s2_valid;
      s3_ch     <= s2_ch;
      s3_p0     <= rnd_b0;
      s3_p1     <= rnd_b1;
      s3_bypass <= s2_bypass;
      s3_raw    <= s2_raw;
    end
  end

  // ---------------- S4: sum, scale, output ----------------
  logic signed [AW-1:0]         y_sum;
  logic signed [IW-1:0]         y_iw;
  logic signed [IW-1:0]         y_sh;
  logic signed [DATA_WIDTH-1:0] y_dw;

  always_comb begin
    // Rounded products carry at most AW-B_FRAC significant bits, so this
    // sum stays inside AW.
    y_sum = s3_p0 + s3_p1;
    y_iw  = sat_iw(y_sum);
    y_sh  = y_iw >>> GUARD;
    y_dw  = sat_dw(y_sh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_channel <= '0;
      out         <= '0;
    end else begin
      out_valid <= s3_valid;
      if (s3_valid) begin
        out_channel <= s3_ch;
        out         <= s3_bypass ? s3_raw : y_dw;
      end
    end
  end

endmodule

// File: tb/tb_filter_iir1_tdm.sv
// ---------------------------------------------------------------------------
// tb_filter_iir1_tdm
//
// Directed bench for filter_iir1_tdm with three channels (so index 3 is an
// out-of-range channel).  Expected outputs are hand-derived from the
// recursion with half-up rounding and saturation.
// ---------------------------------------------------------------------------
module tb_filter_iir1_tdm;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [1:0]        in_channel;
  logic signed [8:0] in;
  logic signed [11:0] b0, b1, a1;
  logic              bypass;
  logic              clear;
  logic              out_valid;
  logic [1:0]        out_channel;
  logic signed [8:0] out;

  always #5 clk = ~clk;

  filter_iir1_tdm #(
    .DATA_WIDTH (9),
    .CHANNELS   (3),
    .COEF_WIDTH (12),
    .A_FRAC     (10),
    .B_FRAC     (10),
    .GUARD      (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_channel  (in_channel),
    .in          (in),
    .b0          (b0),
    .b1          (b1),
    .a1          (a1),
    .bypass      (bypass),
    .clear       (clear),
    .out_valid   (out_valid),
    .out_channel (out_channel),
    .out         (out)
  );

  // Output monitor: one entry per result strobe.
  int q_val[$];
  int q_ch[$];

  always @(negedge clk) begin
    if (out_valid) begin
      q_val.push_back(int'(out));
      q_ch.push_back(int'(out_channel));
      $display("OUT t=%0t ch=%0d val=%0d", $time, out_channel, out);
    end
  end

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string tag, input int obs, input int exp);
    chk_cnt++;
    if (obs == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic set_coef(input int c0, input int c1, input int ca);
    b0 = 12'(c0);
    b1 = 12'(c1);
    a1 = 12'(ca);
  endtask

  task automatic send(input int ch, input int x, input bit byp);
    in_valid   = 1'b1;
    in_channel = 2'(ch);
    in         = 9'(x);
    bypass     = byp;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bypass   = 1'b0;
    in       = '0;
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  // Drives one sample and checks out_valid is low after 3 edges and high,
  // carrying exp, after 4 edges.
  task automatic latency_probe(input string tag, input int ch, input int x,
                               input bit byp, input int exp);
    @(posedge clk);
    #1;
    in_valid   = 1'b1;
    in_channel = 2'(ch);
    in         = 9'(x);
    bypass     = byp;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bypass   = 1'b0;
    in       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_at_3"}, int'(out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_at_4"}, int'(out_valid), 1);
    check({tag, "_value"}, int'(out), exp);
  endtask

  // Step response of b0=b1=256, a1=-512 to in=100 from zero state.
  int dc_exp [10] = '{25, 62, 81, 91, 95, 97, 98, 99, 100, 100};
  int integ_exp [5] = '{64, 127, 128, 128, 128};
  int oor_val [6] = '{0, 0, 0, 10, 20, 30};

  initial begin
    int base;
    int mx;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_channel = '0;
    in         = '0;
    bypass     = 1'b0;
    clear      = 1'b0;
    set_coef(0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out", int'(out), 0);
    check("rst_out_channel", int'(out_channel), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Impulse with unity b0.
    set_coef(1024, 0, 0);
    base = q_val.size();
    latency_probe("imp", 0, 128, 1'b0, 128);
    for (int i = 0; i < 3; i++) send(0, 0, 1'b0);
    drain();
    check("imp_count", q_val.size() - base, 4);
    for (int i = 1; i < 4; i++) check($sformatf("imp_tail%0d", i), q_val[base+i], 0);

    // DC gain of one.
    do_clear();
    set_coef(256, 256, -512);
    base = q_val.size();
    for (int i = 0; i < 20; i++) send(0, 100, 1'b0);
    drain();
    check("dc_count", q_val.size() - base, 20);
    mx = -1000;
    for (int i = 0; i < 20; i++) begin
      if (q_val[base+i] > mx) mx = q_val[base+i];
      if (i < 10) check($sformatf("dc_step%0d", i), q_val[base+i], dc_exp[i]);
      else        check($sformatf("dc_settled%0d", i), q_val[base+i], 100);
    end
    check("dc_no_overshoot", int'(mx > 101), 0);

    // Channel isolation: interleaved opposite-sign DC inputs.
    do_clear();
    base = q_val.size();
    for (int i = 0; i < 20; i++) begin
      send(0, 100, 1'b0);
      send(1, -100, 1'b0);
    end
    drain();
    check("iso_count", q_val.size() - base, 40);
    for (int k = 0; k < 40; k++) check($sformatf("iso_ch%0d", k), q_ch[base+k], k % 2);
    for (int k = 0; k < 10; k++) check($sformatf("iso_ch0_step%0d", k), q_val[base+2*k], dc_exp[k]);
    check("iso_ch0_final", q_val[base+38], 100);
    check("iso_ch1_final", q_val[base+39], -100);

    // Saturation, positive and negative full scale.
    do_clear();
    set_coef(1024, 1024, 0);
    base = q_val.size();
    for (int i = 0; i < 8; i++) send(0, 255, 1'b0);
    drain();
    check("satp_count", q_val.size() - base, 8);
    for (int i = 0; i < 8; i++) check($sformatf("satp%0d", i), q_val[base+i], 255);
    do_clear();
    base = q_val.size();
    for (int i = 0; i < 8; i++) send(0, -256, 1'b0);
    drain();
    check("satn_count", q_val.size() - base, 8);
    for (int i = 0; i < 8; i++) check($sformatf("satn%0d", i), q_val[base+i], -256);

    // Integrator: the stored state must clip instead of wrapping.
    do_clear();
    set_coef(256, 0, -1024);
    base = q_val.size();
    for (int i = 0; i < 5; i++) send(0, 255, 1'b0);
    drain();
    check("integ_count", q_val.size() - base, 5);
    for (int i = 0; i < 5; i++) check($sformatf("integ%0d", i), q_val[base+i], integ_exp[i]);

    // Bypass: raw sample out at full latency, state still updated
    // (b1-only filter echoes the bypassed sample next time).
    do_clear();
    set_coef(0, 1024, 0);
    base = q_val.size();
    latency_probe("byp", 0, -37, 1'b1, -37);
    send(0, 0, 1'b0);
    drain();
    check("byp_count", q_val.size() - base, 2);
    check("byp_state_echo", q_val[base+1], -37);

    // Out-of-range channel is dropped and disturbs no state.
    do_clear();
    base = q_val.size();
    send(0, 10, 1'b0);
    send(1, 20, 1'b0);
    send(2, 30, 1'b0);
    send(3, 99, 1'b0);
    send(0, 0, 1'b0);
    send(1, 0, 1'b0);
    send(2, 0, 1'b0);
    drain();
    check("oor_count", q_val.size() - base, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("oor_val%0d", i), q_val[base+i], oor_val[i]);
      check($sformatf("oor_ch%0d", i), q_ch[base+i], i % 3);
    end

    // Reset with three samples in flight: none may emerge.
    set_coef(1024, 0, 0);
    base = q_val.size();
    send(0, 50, 1'b0);
    send(1, 60, 1'b0);
    send(2, 70, 1'b0);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rst_inflight_pulses", q_val.size() - base, 0);

    // Clear after DC settles: next output is the step response from zero.
    set_coef(256, 256, -512);
    for (int i = 0; i < 20; i++) send(0, 100, 1'b0);
    drain();
    base = q_val.size();
    send(0, 100, 1'b0);
    drain();
    check("pre_clear_settled", q_val[base], 100);
    do_clear();
    base = q_val.size();
    send(0, 100, 1'b0);
    drain();
    check("clear_count", q_val.size() - base, 1);
    check("clear_restart", q_val[base], 25);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/filter_iir1_tdm.md
# filter_iir1_tdm

Parametrised first-order IIR filter, time-multiplexed over several channels, for chroma and colour-difference low-pass and de-emphasis paths. It generalises the fixed-coefficient single-channel chroma low-pass in four ways: runtime coefficients, per-channel state, a valid/channel handshake, and saturating arithmetic with bypass. It sits between the demodulator/mixer outputs and the encoder back end. One instance serves, for example, both SECAM Db/Dr streams or the YUV U/V pair.

## Interface
- DATA_WIDTH, 9: signed sample width of `in` and `out`.
- CHANNELS, 2: number of independent filter states, ≥1.
- COEF_WIDTH, 12: signed coefficient width.
- A_FRAC, 10: fractional bits of `a1`.
- B_FRAC, 10: fractional bits of `b0` and `b1`.
- GUARD, 1: extra LSBs of internal precision. Internal width IW = DATA_WIDTH+GUARD+1.

- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample strobe.
- in_channel  in  $clog2(CHANNELS) (min 1)  channel index of the sample.
- in  in  DATA_WIDTH  signed sample.
- b0, b1, a1  in  COEF_WIDTH each  signed coefficients, captured with each sample.
- bypass  in  1  captured with each sample; output is the unfiltered sample.
- clear  in  1  synchronous clear of all channel states.
- out_valid  out  1  result strobe.
- out_channel  out  width of in_channel  channel of the result.
- out  out  DATA_WIDTH  signed result.

## Operation
- Transfer function: H(z) = (b0 + b1·z⁻¹)/(1 + a1·z⁻¹).
- Per-channel recursion: w[n] = x[n] − a1·w[n−1], then y[n] = b0·w[n] + b1·w[n−1].
- The sign of `a1` is the denominator sign. The block negates it internally. Callers never pre-negate.
- x = in sign-extended to IW, then shifted left by GUARD.
- Rounding of every product: (p + 2^(F−1)) >>> F, arithmetic, with F = A_FRAC or B_FRAC.
- w saturates to IW signed before it is stored. y saturates to IW, is shifted right arithmetically by GUARD, then saturates to DATA_WIDTH.
- Products are formed at full width (IW+COEF_WIDTH). No silent wrap anywhere.
- Pipeline stages:
  - S1 registers sample, channel, coefficients and bypass.
  - S2 reads state[ch], computes w, writes state[ch], and registers w and w_prev.
  - S3 registers both b-products.
  - S4 sums, saturates, scales and drives the outputs.
- The S2 state read→write loop is one cycle. Back-to-back samples of the same channel are legal and correct.
- in_channel ≥ CHANNELS: the sample is dropped. No state change and no out_valid.
- bypass=1: out = in, same latency, and the state of that channel is still updated. Coefficient and bypass changes therefore take effect exactly on sample boundaries.
- clear (in any cycle): all states go to 0 at the next edge. In-flight samples still emerge. A sample in S2 in the same cycle as clear is computed with w_prev=0 and its write is overridden to 0.

## Timing
- Latency: in_valid at edge k → out_valid high after edge k+4. Throughput is one sample per clock.
- out_valid is a one-cycle pulse per accepted sample. out and out_channel hold their value between pulses.
- Reset values: out_valid=0, out=0, out_channel=0, all states 0, all pipeline valids 0.
- Reset asserted mid-stream: every in-flight sample is discarded. No out_valid is produced for them after release.
- No backpressure. The downstream consumer accepts every out_valid.

## Test plan
- Impulse: b0=1024, b1=0, a1=0, in=128 once then 0 → out=128 with out_valid exactly 4 cycles after in_valid, then 0.
- DC gain: b0=b1=256, a1=−512, in=100 every cycle on ch0 → out settles to 100±1 within 20 samples, with no overshoot above 101.
- Channel isolation: same coefficients, alternating ch0=100 and ch1=−100 → out_channel alternates, and each channel settles to its own value ±1.
- Saturation: b0=b1=1024, a1=0, in=255 continuous → out=255, never wraps negative. Mirror with in=−256 → out=−256.
- Bypass and out-of-range: bypass=1, in=−37 → out=−37 at latency 4. With CHANNELS=3, in_channel=3 → no out_valid and ch0–2 states unchanged.
- Reset and clear mid-stream: pulse rst_n low while 3 samples are in flight → zero out_valid pulses follow. Assert clear while DC-settled → the next output equals the b0·x step response from zero.
